// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the programmable interrupt controller.
// Register offsets (word index inside the 32-byte window), FSM states, default base.
// No logic here; imported by int_ctrl and int_prio_enc.
package int_ctrl_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_7F20;

    localparam logic [2:0] OFF_PEND = 3'd0;
    localparam logic [2:0] OFF_MASK = 3'd1;
    localparam logic [2:0] OFF_MODE = 3'd2;
    localparam logic [2:0] OFF_CLR  = 3'd3;
    localparam logic [2:0] OFF_VEC  = 3'd4;
    localparam logic [2:0] OFF_EOI  = 3'd5;
    localparam logic [2:0] OFF_CNT  = 3'd6;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index of act wins, valid = any bit set.
// Latency: purely combinational.
// Backpressure: none.
module int_prio_enc #(
    parameter int N_SRC = 6
) (
    input  logic [N_SRC-1:0] act,
    output logic             valid,
    output logic [4:0]       id
);

    // Scan from the lowest-priority end so the lowest set index is the last one assigned.
    always_comb begin
        valid = |act;
        id    = 5'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i]) id = 5'(i);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: pending/mask/mode regs, priority, claim/EOI handshake.
// Latency: rd and irq_out are combinational from registers; edge sources pend one cycle after the rise.
// Backpressure: none; every bus access completes in its own cycle.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 6,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic [31:0]      adr,
    input  logic             we,
    input  logic             re,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic [N_SRC-1:0] irq_out,
    output logic             irq_any
);

    state_t             state, state_nxt;
    logic [N_SRC-1:0]   mask, mode, pend_edge, prev;
    logic [4:0]         isr_id;
    logic [31:0]        cnt;

    logic               sel;
    logic [2:0]         off;
    logic [N_SRC-1:0]   pend, act, mode_nxt, clr_vec, set_vec, higher;
    logic               valid, claim, eoi;
    logic [4:0]         win;

    assign sel = (adr[31:5] == BASE_ADDR[31:5]);
    assign off = adr[4:2];

    // Level sources bypass the latch entirely, so CLR and claim cannot touch them.
    assign pend = (pend_edge & mode) | (src & ~mode);
    assign act  = pend & mask;

    int_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .act   (act),
        .valid (valid),
        .id    (win)
    );

    assign claim    = re & sel & (off == OFF_VEC) & (state == ST_IDLE) & valid;
    assign eoi      = we & sel & (off == OFF_EOI) & (state == ST_SERVICE) & (wd[4:0] == isr_id);
    assign mode_nxt = (we && sel && off == OFF_MODE) ? wd[N_SRC-1:0] : mode;
    assign set_vec  = src & ~prev;
    assign clr_vec  = ((we && sel && off == OFF_CLR) ? wd[N_SRC-1:0] : '0)
                    | (claim ? (N_SRC'(1) << win) : '0);

    // Register file, edge latch and claim counter; a fresh edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask      <= '0;
            mode      <= '1;
            pend_edge <= '0;
            prev      <= '0;
            isr_id    <= 5'd0;
            cnt       <= 32'd0;
        end else begin
            prev      <= src;
            mode      <= mode_nxt;
            // Masking with the new mode drops latched bits of sources moving to level.
            pend_edge <= ((pend_edge & ~clr_vec) | set_vec) & mode_nxt;
            if (we && sel && off == OFF_MASK) mask <= wd[N_SRC-1:0];
            if (claim) begin
                isr_id <= win;
                cnt    <= cnt + 32'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and request outputs; in service only strictly higher priority preempts.
    always_comb begin
        state_nxt = state;
        irq_out   = act;
        for (int i = 0; i < N_SRC; i++) higher[i] = (5'(i) < isr_id);
        case (state)
            ST_IDLE: begin
                if (claim) state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                irq_out = act & higher;
                if (eoi) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign irq_any = |irq_out;

    // Read mux; anything outside the window or write-only reads as zero.
    always_comb begin
        rd = 32'd0;
        if (sel) begin
            case (off)
                OFF_PEND: rd = 32'(pend);
                OFF_MASK: rd = 32'(mask);
                OFF_MODE: rd = 32'(mode);
                OFF_VEC:  rd = {valid, 26'd0, win};
                OFF_CNT:  rd = cnt;
                default:  rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  src;
    logic [31:0] adr, wd, rd;
    logic        we, re;
    logic [5:0]  irq_out;
    logic        irq_any;

    int checks = 0;
    int errors = 0;

    int_ctrl #(.N_SRC(6), .BASE_ADDR(32'h7F20)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .adr     (adr),
        .we      (we),
        .re      (re),
        .wd      (wd),
        .rd      (rd),
        .irq_out (irq_out),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] data);
        adr = 32'h7F20 | (32'(off) << 2);
        wd  = data;
        we  = 1'b1;
        cyc();
        we  = 1'b0;
        wd  = 32'd0;
        adr = 32'd0;
    endtask

    task automatic rdc(input logic [2:0] off, input logic strobe, input logic [31:0] exp,
                       input string tag);
        adr = 32'h7F20 | (32'(off) << 2);
        re  = strobe;
        #1;
        chk(rd, exp, tag);
        cyc();
        re  = 1'b0;
        adr = 32'd0;
    endtask

    task automatic pulse(input logic [5:0] bits);
        src = src | bits;
        cyc();
        src = src & ~bits;
    endtask

    initial begin
        reset = 1'b1; src = '0; adr = '0; wd = '0; we = 1'b0; re = 1'b0;
        #1;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        // reset state
        chk(32'(irq_out), 32'h0, "rst_irq_out");
        chk(32'(irq_any), 32'h0, "rst_irq_any");
        rdc(OFF_PEND, 1'b1, 32'h0,  "rst_pend");
        rdc(OFF_MODE, 1'b1, 32'h3F, "rst_mode");
        rdc(OFF_CNT,  1'b1, 32'h0,  "rst_cnt");
        rdc(OFF_VEC,  1'b1, 32'h0,  "rst_vec_invalid");
        rdc(OFF_CNT,  1'b1, 32'h0,  "rst_cnt_no_claim");

        // 1: edge on src[1]
        wr(OFF_MASK, 32'h3F);
        pulse(6'h02);
        chk(32'(irq_out), 32'h02, "t1_irq_out");
        rdc(OFF_PEND, 1'b1, 32'h02, "t1_pend");

        // 2: bits 1 and 3 pending, claim id 1
        pulse(6'h08);
        chk(32'(irq_out), 32'h0A, "t2_irq_pre");
        rdc(OFF_VEC, 1'b1, 32'h8000_0001, "t2_vec_claim1");
        chk(32'(irq_out), 32'h00, "t2_irq_service");
        rdc(OFF_CNT,  1'b1, 32'h1,  "t2_cnt");
        rdc(OFF_PEND, 1'b1, 32'h08, "t2_pend_bit1_clr");
        wr(OFF_EOI, 32'h1);
        chk(32'(irq_out), 32'h08, "t2_irq_after_eoi");
        rdc(OFF_VEC, 1'b1, 32'h8000_0003, "t2_vec_claim3");
        chk(32'(irq_out), 32'h00, "t2_irq_service3");

        // 3: preemption inside SERVICE(id=3)
        pulse(6'h01);
        chk(32'(irq_out), 32'h01, "t3_preempt");
        rdc(OFF_VEC, 1'b1, 32'h8000_0000, "t3_vec_no_reclaim");
        rdc(OFF_CNT, 1'b1, 32'h2, "t3_cnt_unchanged");
        adr = 32'h7F50; re = 1'b1; #1;
        chk(rd, 32'h0, "t3_unselected_rd");
        cyc(); re = 1'b0; adr = '0;
        pulse(6'h10);
        chk(32'(irq_out), 32'h01, "t3_low_prio_blocked");
        rdc(OFF_PEND, 1'b1, 32'h11, "t3_pend");

        // 4: EOI id matching
        wr(OFF_EOI, 32'h2);
        chk(32'(irq_out), 32'h01, "t4_eoi_mismatch");
        wr(OFF_EOI, 32'h3);
        chk(32'(irq_out), 32'h11, "t4_eoi_match");
        chk(32'(irq_any), 32'h1, "t4_irq_any");

        // 5: set-beats-clear, level mode, mask
        wr(OFF_CLR, 32'h11);
        rdc(OFF_PEND, 1'b1, 32'h0, "t5_clr_all");
        chk(32'(irq_any), 32'h0, "t5_irq_any_zero");
        src = 6'h04;
        wr(OFF_CLR, 32'h04);
        src = 6'h00;
        rdc(OFF_PEND, 1'b1, 32'h04, "t5_set_wins");
        wr(OFF_MODE, 32'h1F);
        src = 6'h20; #1;
        rdc(OFF_PEND, 1'b1, 32'h24, "t5_level_high");
        wr(OFF_CLR, 32'h20);
        rdc(OFF_PEND, 1'b1, 32'h24, "t5_level_clr_noeffect");
        src = 6'h00; #1;
        rdc(OFF_PEND, 1'b1, 32'h04, "t5_level_low");
        src = 6'h20;
        wr(OFF_MASK, 32'h0);
        chk(32'(irq_out), 32'h0, "t5_masked_irq");
        rdc(OFF_PEND, 1'b1, 32'h24, "t5_masked_pend");

        // 6: reset in SERVICE
        wr(OFF_MASK, 32'h3F);
        rdc(OFF_VEC, 1'b1, 32'h8000_0002, "t6_vec_claim2");
        rdc(OFF_PEND, 1'b1, 32'h20, "t6_pend_after_claim");
        rdc(OFF_CNT,  1'b1, 32'h3,  "t6_cnt");
        reset = 1'b1;
        cyc();
        chk(32'(irq_any), 32'h0, "t6_rst_irq_any");
        rdc(OFF_PEND, 1'b0, 32'h0,  "t6_rst_pend");
        rdc(OFF_VEC,  1'b0, 32'h0,  "t6_rst_vec");
        rdc(OFF_CNT,  1'b0, 32'h0,  "t6_rst_cnt");
        rdc(OFF_MODE, 1'b0, 32'h3F, "t6_rst_mode");
        src = 6'h00;
        reset = 1'b0;
        cyc();
        rdc(OFF_PEND, 1'b1, 32'h0, "t6_post_rst_pend");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
